fixed_to_float_seq: RTL
=======================

Name: fixed_to_float_seq

Overview:
- Sequential two's-complement fixed-point (IW.FW) to IEEE-style float (1 sign, EW exponent, MW mantissa) converter.
- Parametrised successor of the 8.8 → half-precision conversion program; same start/ack handshake, so top-level benches drive it the same way.
- Normalises serially (one shift per cycle). Adds selectable rounding, overflow saturation and zero/underflow handling.

Parameters:
- IW, 8, integer bits of input, sign bit included
- FW, 8, fraction bits of input
- EW, 5, exponent width of output
- MW, 10, stored mantissa width of output (hidden bit implicit)
- localparam W = IW+FW, input width
- localparam BIAS = 2**(EW-1)-1, exponent bias (15 at defaults)

Ports:
- clk, in, 1, rising-edge clock
- reset, in, 1, asynchronous active-low reset
- start, in, 1, request; conversion begins on a 0→1 edge sampled in IDLE
- rnd_mode, in, 1, 0 = truncate, 1 = round-to-nearest-even; captured with fix_in
- fix_in, in, W, two's-complement operand; captured on the start edge
- flt_out, out, 1+EW+MW, result {sign, biased exponent, mantissa}
- ack, out, 1, one-cycle done pulse
- busy, out, 1, high from capture through the DONE cycle
- ovf, out, 1, result saturated to infinity; valid with ack

Behaviour:
- Reset (async, low) forces state IDLE and clears flt_out, ack, busy, ovf and the start-edge register. Reset mid-conversion abandons the operation; no ack is produced.
- States: IDLE, LOAD, NORM, ROUND, DONE.
- IDLE:
  - Edge detect is start & ~start_q.
  - On an edge: capture fix_in and rnd_mode, busy=1, go to LOAD.
  - start held high for several cycles gives exactly one conversion.
- LOAD:
  - sign = fix_in[W-1]; mag = sign ? -fix_in : fix_in, as W-bit unsigned.
  - The most negative input gives mag = 2^(W-1), which is correct.
  - If mag==0 go to DONE with result 0x0000, sign forced to 0. Otherwise k=0, go to NORM.
- NORM:
  - If mag[W-1]==0: mag <<= 1, k++, stay in NORM.
  - Else go to ROUND.
  - Takes k+1 cycles, where k = leading zeros of mag.
- ROUND:
  - Exponent and mantissa:
    - unbiased exp = (IW-1) - k
    - e = unbiased + BIAS
    - mant = mag[W-2 -: MW]
    - If W-1 < MW, zero-pad mant on the LSB side.
  - Rounding:
    - Truncate: use mant as is.
    - RNE: guard = next bit below mant; sticky = OR of the remaining lower bits; increment when guard & (sticky | mant[0]).
    - Mantissa carry-out: mant=0, e++.
  - Range limits:
    - e <= 0: flush to signed zero, ovf=0. Subnormals are not produced.
    - e >= 2^EW-1: flt_out = {sign, all-ones, 0}, ovf=1.
  - Go to DONE.
- DONE:
  - flt_out updated, ack=1 for exactly this cycle, then IDLE with busy=0.
  - flt_out holds until the next DONE.
- Latency from the capture edge to ack high:
  - nonzero input: k+3 cycles
  - zero input: 1 cycle
  - worst case: W+2 cycles
- A start edge while busy is ignored and not queued.
- Arithmetic: exponent computed in EW+2 signed bits so the underflow and overflow comparisons are exact.

Decomposition:
- Package fxfl_pkg holds:
  - the state enum (IDLE, LOAD, NORM, ROUND, DONE)
  - the rounding-mode enum (RND_TRUNC, RND_RNE)
  - a bias function of EW
- Sub-module fxfl_round: combinational. Inputs: normalised mag, k, sign, mode. Outputs: packed float and ovf.
- Keep the FSM, capture registers, edge detect and shifter in the top module.

Test Plan:
- Defaults, truncate: fix_in 0x0001 → flt_out 0x1C00; 0x0003 → 0x2200. ack k+3 cycles after capture (k=15 → 18 cycles; k=14 → 17 cycles).
- Defaults, negatives and extremes, truncate: 0xFFFF → 0x9C00; 0x8000 → 0xD800, no overflow wrap; 0x0000 → 0x0000 with ack 1 cycle after capture.
- Rounding: 0x7FFF truncate → 0x57FF; same input with RNE → 0x5800 via mantissa carry. 1000 random inputs in truncate mode match the bench math model bit-exact.
- Handshake: start held 2 cycles → exactly one ack pulse. Second start edge during busy → ignored, result unchanged. flt_out stable until the next ack.
- Reset mid-op: assert reset (low) in NORM → busy, ack and flt_out go to 0 immediately; a new start afterwards converts correctly.
- Parametric, IW=12 FW=4 EW=4 MW=3, BIAS=7:
  - 0x7FF0 = 2047 → e=10+7=17 ≥ 15, so flt_out = 0x78 (sign 0, exponent all-ones, mantissa 0), ovf=1.
  - 0x0001 = 1/16 → e=-4+7=3, so flt_out = 0x18.

Source files
------------

// File: rtl/fxfl_pkg.sv
// Shared types and helpers for the sequential fixed-to-float converter.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package fxfl_pkg;

   // Conversion FSM states, in the order an operand visits them.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      NORM  = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } fxfl_state_e;

   // Rounding applied to the bits that fall below the stored mantissa.
   typedef enum logic {
      RND_TRUNC = 1'b0,
      RND_RNE   = 1'b1
   } rnd_mode_e;

   // Exponent bias for an ew-bit biased exponent field.
   function automatic int bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

endpackage

// File: rtl/fxfl_round.sv
// Packs a normalised magnitude into {sign, exponent, mantissa} with rounding and range limits.
// Latency: combinational.
// Backpressure: none; the caller samples the outputs when it needs them.
module fxfl_round
   import fxfl_pkg::*;
#(
   parameter int IW = 8,
   parameter int FW = 8,
   parameter int EW = 5,
   parameter int MW = 10,
   parameter int KW = $clog2(IW + FW)
) (
   input  logic [IW+FW-1:0] mag,
   input  logic [KW-1:0]    k,
   input  logic             sign,
   input  rnd_mode_e        mode,
   output logic [EW+MW:0]   flt,
   output logic             ovf
);

   localparam int W       = IW + FW;
   localparam int BIAS    = bias(EW);
   // Biased exponent of a magnitude whose leading one sits in bit W-1.
   localparam int EXP_TOP = (IW - 1) + BIAS;
   // Exponent field value reserved for infinity.
   localparam int EXP_MAX = (1 << EW) - 1;

   // Two spare bits keep both the underflow and overflow compares exact.
   typedef logic signed [EW+1:0] exp_t;

   // Bits below the hidden one, zero-padded so a mantissa plus guard always exists.
   logic [W+MW-1:0] pad;
   logic [MW-1:0]   mant;
   logic            guard;
   logic            sticky;
   logic            rnd_up;
   logic [MW:0]     mant_inc;
   logic [MW-1:0]   mant_fin;
   exp_t            e_raw;
   exp_t            e_fin;

   assign pad    = {mag[W-2:0], {(MW + 1){1'b0}}};
   assign mant   = pad[W+MW-1 -: MW];
   assign guard  = pad[W-1];
   assign sticky = |pad[W-2:0];

   // Round-to-nearest-even bumps on more than half, or exactly half with an odd lsb.
   assign rnd_up   = (mode == RND_RNE) & guard & (sticky | mant[0]);
   assign mant_inc = {1'b0, mant} + {{MW{1'b0}}, rnd_up};
   // On a carry-out the low bits are already zero, so the mantissa needs no fix-up.
   assign mant_fin = mant_inc[MW-1:0];

   assign e_raw = exp_t'(EXP_TOP) - exp_t'(k);
   assign e_fin = e_raw + exp_t'(mant_inc[MW]);

   // Select normal result, flush-to-zero or saturate-to-infinity.
   always_comb begin
      flt = {sign, e_fin[EW-1:0], mant_fin};
      ovf = 1'b0;
      // An un-normalised magnitude can only be zero; no subnormals are produced.
      if (!mag[W-1] || (e_fin <= exp_t'(0))) begin
         flt = {sign, {(EW + MW){1'b0}}};
      end else if (e_fin >= exp_t'(EXP_MAX)) begin
         flt = {sign, {EW{1'b1}}, {MW{1'b0}}};
         ovf = 1'b1;
      end
   end

endmodule

// File: rtl/fixed_to_float_seq.sv
// Sequential two's-complement IW.FW fixed-point to {sign, EW exponent, MW mantissa} float converter.
// Latency: capture edge to ack is k+3 cycles (k = leading zeros of |fix_in|), 1 cycle for zero, W+2 worst case.
// Backpressure: start is edge-triggered; edges while busy are dropped, never queued.
module fixed_to_float_seq
   import fxfl_pkg::*;
#(
   parameter int IW = 8,
   parameter int FW = 8,
   parameter int EW = 5,
   parameter int MW = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               rnd_mode,
   input  logic [IW+FW-1:0]   fix_in,
   output logic [EW+MW:0]     flt_out,
   output logic               ack,
   output logic               busy,
   output logic               ovf
);

   localparam int W  = IW + FW;
   // k never exceeds W-1 because a zero magnitude bypasses normalisation.
   localparam int KW = $clog2(W);

   fxfl_state_e     state;
   logic            start_q;
   logic            start_edge;
   logic [W-1:0]    fix_r;
   rnd_mode_e       mode_r;
   logic            sign_r;
   logic [W-1:0]    mag;
   logic [W-1:0]    mag_ld;
   logic [KW-1:0]   k;
   logic [EW+MW:0]  rnd_flt;
   logic            rnd_ovf;

   assign start_edge = start & ~start_q;

   // The most negative operand negates to 2^(W-1), which is the right unsigned magnitude.
   assign mag_ld = fix_r[W-1] ? (~fix_r + 1'b1) : fix_r;

   fxfl_round #(
      .IW (IW),
      .FW (FW),
      .EW (EW),
      .MW (MW),
      .KW (KW)
   ) u_round (
      .mag  (mag),
      .k    (k),
      .sign (sign_r),
      .mode (mode_r),
      .flt  (rnd_flt),
      .ovf  (rnd_ovf)
   );

   // Conversion FSM: capture, take magnitude, shift one bit per cycle, round, report.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         start_q <= 1'b0;
         fix_r   <= '0;
         mode_r  <= RND_TRUNC;
         sign_r  <= 1'b0;
         mag     <= '0;
         k       <= '0;
         flt_out <= '0;
         ack     <= 1'b0;
         busy    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         // Tracked every cycle so an edge that arrives while busy is consumed, not deferred.
         start_q <= start;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  fix_r  <= fix_in;
                  mode_r <= rnd_mode_e'(rnd_mode);
                  busy   <= 1'b1;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               sign_r <= fix_r[W-1];
               mag    <= mag_ld;
               k      <= '0;
               if (mag_ld == '0) begin
                  // Zero skips normalisation and always reports positive zero.
                  flt_out <= '0;
                  ovf     <= 1'b0;
                  ack     <= 1'b1;
                  state   <= DONE;
               end else begin
                  state <= NORM;
               end
            end
            NORM: begin
               if (!mag[W-1]) begin
                  mag <= {mag[W-2:0], 1'b0};
                  k   <= k + 1'b1;
               end else begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               flt_out <= rnd_flt;
               ovf     <= rnd_ovf;
               ack     <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               ack   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
